// File: rtl/router_fifo.sv
// rtl/router_fifo.sv - 16x9 router output FIFO with header flag and packet-length tracking
module router_fifo (
  input  logic       clk,
  input  logic       resetn,
  input  logic       soft_reset,
  input  logic       write_enb,
  input  logic       read_enb,
  input  logic       lfd_state,
  input  logic [7:0] data_in,
  output logic       full,
  output logic       empty,
  output logic [7:0] data_out
);

  logic [8:0] mem_q [16];
  logic [4:0] wr_ptr_q, rd_ptr_q;
  logic [6:0] count_q, count_d;
  logic [7:0] data_out_q, data_out_d;
  logic       lfd_q;
  logic       done_q, done_d;
  logic       do_wr, do_rd;
  logic [8:0] rd_word;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[4] != rd_ptr_q[4]) && (wr_ptr_q[3:0] == rd_ptr_q[3:0]);
  assign do_wr    = write_enb && !full;
  assign do_rd    = read_enb && !empty;
  assign rd_word  = mem_q[rd_ptr_q[3:0]];
  assign data_out = data_out_q;

  // A header loads payload length plus the parity byte; data_out clears one idle edge after parity.
  always_comb begin
    count_d    = count_q;
    done_d     = 1'b0;
    data_out_d = data_out_q;
    if (do_rd) begin
      data_out_d = rd_word[7:0];
      if (rd_word[8]) begin
        count_d = {1'b0, rd_word[7:2]} + 7'd1;
      end else if (count_q != 7'd0) begin
        count_d = count_q - 7'd1;
        done_d  = (count_q == 7'd1);
      end
    end else if (done_q) begin
      data_out_d = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q   <= 5'd0;
      rd_ptr_q   <= 5'd0;
      count_q    <= 7'd0;
      data_out_q <= 8'h00;
      lfd_q      <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < 16; i++) mem_q[i[3:0]] <= 9'h000;
    end else if (soft_reset) begin
      wr_ptr_q   <= 5'd0;
      rd_ptr_q   <= 5'd0;
      count_q    <= 7'd0;
      data_out_q <= 8'h00;
      lfd_q      <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < 16; i++) mem_q[i[3:0]][8] <= 1'b0;
    end else begin
      count_q    <= count_d;
      data_out_q <= data_out_d;
      done_q     <= done_d;
      // lfd_state leads the register-stage byte by one cycle, so the delayed copy tags the word.
      lfd_q      <= lfd_state;
      if (do_wr) begin
        mem_q[wr_ptr_q[3:0]] <= {lfd_q, data_in};
        wr_ptr_q             <= wr_ptr_q + 5'd1;
      end
      if (do_rd) rd_ptr_q <= rd_ptr_q + 5'd1;
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
// tb/tb_router_fifo.sv - self-checking bench for router_fifo against a queue-based model
module tb_router_fifo;

  logic       clk = 1'b0;
  logic       resetn, soft_reset, write_enb, read_enb, lfd_state;
  logic [7:0] data_in;
  logic       full, empty;
  logic [7:0] data_out;

  int n_vec = 0;
  int n_err = 0;

  logic [8:0] mq[$];
  logic [7:0] m_dout;
  int         m_cnt;
  logic       m_lfd, m_fin;

  router_fifo dut (
    .clk       (clk),
    .resetn    (resetn),
    .soft_reset(soft_reset),
    .write_enb (write_enb),
    .read_enb  (read_enb),
    .lfd_state (lfd_state),
    .data_in   (data_in),
    .full      (full),
    .empty     (empty),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic rn, input logic sr, input logic we, input logic re,
                       input logic lfd, input logic [7:0] din);
    logic       f, e, fin_n;
    logic [8:0] w;
    if (!rn || sr) begin
      mq.delete();
      m_dout = 8'h00;
      m_cnt  = 0;
      m_lfd  = 1'b0;
      m_fin  = 1'b0;
    end else begin
      f     = (mq.size() == 16);
      e     = (mq.size() == 0);
      fin_n = 1'b0;
      if (re && !e) begin
        w      = mq.pop_front();
        m_dout = w[7:0];
        if (w[8]) m_cnt = int'(w[7:2]) + 1;
        else if (m_cnt != 0) begin
          m_cnt = m_cnt - 1;
          fin_n = (m_cnt == 0);
        end
      end else if (m_fin) begin
        m_dout = 8'h00;
      end
      if (we && !f) mq.push_back({m_lfd, din});
      m_lfd = lfd;
      m_fin = fin_n;
    end
  endtask

  task automatic step(input logic rn, input logic sr, input logic we, input logic re,
                      input logic lfd, input logic [7:0] din);
    resetn     = rn;
    soft_reset = sr;
    write_enb  = we;
    read_enb   = re;
    lfd_state  = lfd;
    data_in    = din;
    @(posedge clk);
    model(rn, sr, we, re, lfd, din);
    #1;
    chk("data_out", data_out, m_dout);
    chk("empty", 8'(empty), 8'(mq.size() == 0));
    chk("full", 8'(full), 8'(mq.size() == 16));
    chk("full_and_empty", 8'(full && empty), 8'h00);
  endtask

  task automatic wr(input logic [7:0] d, input logic lfd_next);
    step(1'b1, 1'b0, 1'b1, 1'b0, lfd_next, d);
  endtask

  task automatic rd();
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic idle(input logic lfd_next);
    step(1'b1, 1'b0, 1'b0, 1'b0, lfd_next, 8'h00);
  endtask

  initial begin
    resetn = 1'b0; soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
    lfd_state = 1'b0; data_in = 8'h00;

    // reset state
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF);
    chk("reset_empty", 8'(empty), 8'h01);
    chk("reset_dout", data_out, 8'h00);

    // single packet: header 0D, payload 11 22 33, parity 2F
    idle(1'b1);
    wr(8'h0D, 1'b0); wr(8'h11, 1'b0); wr(8'h22, 1'b0); wr(8'h33, 1'b0); wr(8'h2F, 1'b0);
    chk("pkt_not_empty", 8'(empty), 8'h00);
    rd(); chk("pkt_hdr", data_out, 8'h0D);
    rd(); rd(); rd();
    rd(); chk("pkt_parity", data_out, 8'h2F);
    idle(1'b0);
    chk("pkt_cleared", data_out, 8'h00);
    chk("pkt_empty", 8'(empty), 8'h01);
    rd(); chk("read_when_empty", data_out, 8'h00);

    // fill to 16, overflow write, drain
    for (int i = 0; i < 16; i++) wr(8'($urandom), 1'b0);
    chk("full_after_16", 8'(full), 8'h01);
    wr(8'hA5, 1'b0);
    rd(); chk("full_clear_after_read", 8'(full), 8'h00);
    for (int i = 0; i < 15; i++) rd();
    idle(1'b0);

    // 8 stored, concurrent read/write for 4 cycles
    for (int i = 0; i < 8; i++) wr(8'($urandom), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < 8; i++) rd();
    chk("concurrent_drain_empty", 8'(empty), 8'h01);

    // concurrent read/write while full and while empty
    for (int i = 0; i < 16; i++) wr(8'($urandom), 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h77);
    for (int i = 0; i < 15; i++) rd();
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h66);
    rd();

    // fill, drain, then refill across the pointer wrap while reading
    for (int i = 0; i < 16; i++) wr(8'($urandom), 1'b0);
    for (int i = 0; i < 16; i++) rd();
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b1, 1'($urandom % 2), 1'b0, 8'($urandom));
    for (int i = 0; i < 16; i++) rd();

    // soft reset mid-packet with 6 words stored, then a clean packet
    idle(1'b1);
    wr(8'h14, 1'b0);
    for (int i = 0; i < 5; i++) wr(8'($urandom), 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'hEE);
    chk("soft_empty", 8'(empty), 8'h01);
    chk("soft_dout", data_out, 8'h00);
    idle(1'b1);
    wr(8'h04, 1'b0); wr(8'h5A, 1'b0); wr(8'h3C, 1'b0);
    rd(); chk("post_soft_hdr", data_out, 8'h04);
    rd(); rd(); idle(1'b0);
    chk("post_soft_cleared", data_out, 8'h00);

    // hard reset during a read burst
    idle(1'b1);
    wr(8'h10, 1'b0);
    for (int i = 0; i < 5; i++) wr(8'($urandom), 1'b0);
    rd(); rd(); rd();
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("hard_dout", data_out, 8'h00);
    chk("hard_empty", 8'(empty), 8'h01);
    chk("hard_count", 8'(dut.count_q), 8'h00);

    // randomized traffic with write-heavy and read-heavy phases
    for (int b = 0; b < 10; b++) begin
      for (int i = 0; i < 40; i++) begin
        step(($urandom % 150) != 0, ($urandom % 80) == 0,
             ($urandom % 100) < ((b % 2 == 0) ? 80 : 30),
             ($urandom % 100) < ((b % 2 == 0) ? 30 : 80),
             ($urandom % 5) == 0, 8'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
